// File: rtl/ppg_led_adc_sequencer.sv
// ppg_led_adc_sequencer: alternates IR/red LEDs, fires one settled ADC conversion per
// phase and routes each result to its channel with a one-cycle valid strobe.
module ppg_led_adc_sequencer #(
   parameter int PHASE_CYCLES  = 500000,
   parameter int SETTLE_CYCLES = 50000,
   parameter int ADC_TIMEOUT   = 1000
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       Enable,
   input  logic [7:0] ADC_Data,
   input  logic       ADC_Done,
   input  logic       Err_Clear,
   output logic       LED_IR,
   output logic       LED_Red,
   output logic       ADC_Start,
   output logic [7:0] IR_ADC_Value,
   output logic       IR_Valid,
   output logic [7:0] Red_ADC_Value,
   output logic       Red_Valid,
   output logic       Channel_Sel,
   output logic       Timeout_Err
);
   localparam int CW = $clog2(PHASE_CYCLES);
   localparam int WW = $clog2(ADC_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, HOLD} state_t;
   state_t        r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [WW-1:0] r_wcnt, w_wcnt;
   logic [7:0]    r_ir_val, w_ir_val, r_red_val, w_red_val;
   logic          r_ch, w_ch, r_start, w_start, r_ir_vld, w_ir_vld, r_red_vld, w_red_vld;
   logic          r_led_ir, r_led_red, r_err, w_tmo, w_phase_end;
   assign w_phase_end = r_cnt == CW'(PHASE_CYCLES - 1);
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_wcnt    <= '0;
         r_ch      <= 1'b0;
         r_start   <= 1'b0;
         r_ir_val  <= '0;
         r_red_val <= '0;
         r_ir_vld  <= 1'b0;
         r_red_vld <= 1'b0;
         r_led_ir  <= 1'b0;
         r_led_red <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_wcnt    <= w_wcnt;
         r_ch      <= w_ch;
         r_start   <= w_start;
         r_ir_val  <= w_ir_val;
         r_red_val <= w_red_val;
         r_ir_vld  <= w_ir_vld;
         r_red_vld <= w_red_vld;
         r_led_ir  <= Enable & ~w_ch;
         r_led_red <= Enable & w_ch;
         r_err     <= w_tmo | (r_err & ~Err_Clear);
      end
   end
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt + CW'(1);
      w_wcnt    = r_wcnt;
      w_ch      = r_ch;
      w_start   = 1'b0;
      w_ir_val  = r_ir_val;
      w_red_val = r_red_val;
      w_ir_vld  = 1'b0;
      w_red_vld = 1'b0;
      w_tmo     = 1'b0;
      if (!Enable) begin
         w_state = IDLE;
         w_cnt   = '0;
         w_wcnt  = '0;
         w_ch    = 1'b0;
      end else if (r_state == IDLE) begin
         w_state = SETTLE;
         w_cnt   = '0;
      end else if (w_phase_end) begin
         // phase boundary overrides everything, abandoning any conversion in flight
         w_state = SETTLE;
         w_cnt   = '0;
         w_ch    = ~r_ch;
      end else if (r_state == SETTLE && r_cnt == CW'(SETTLE_CYCLES - 1)) begin
         w_state = CONVERT;
         w_start = 1'b1;
         w_wcnt  = '0;
      end else if (r_state == CONVERT) begin
         w_wcnt = r_wcnt + WW'(1);
         if (ADC_Done) begin
            w_state   = HOLD;
            w_ir_val  = r_ch ? r_ir_val : ADC_Data;
            w_red_val = r_ch ? ADC_Data : r_red_val;
            w_ir_vld  = ~r_ch;
            w_red_vld = r_ch;
         end else if (r_wcnt == WW'(ADC_TIMEOUT - 1)) begin
            w_state = HOLD;
            w_tmo   = 1'b1;
         end
      end
   end
   assign LED_IR        = r_led_ir;
   assign LED_Red       = r_led_red;
   assign ADC_Start     = r_start;
   assign IR_ADC_Value  = r_ir_val;
   assign IR_Valid      = r_ir_vld;
   assign Red_ADC_Value = r_red_val;
   assign Red_Valid     = r_red_vld;
   assign Channel_Sel   = r_ch;
   assign Timeout_Err   = r_err;
endmodule

// File: doc/ppg_led_adc_sequencer.md
Name: ppg_led_adc_sequencer

Overview:
Controller for the oximeter front-end and the two FIR channels (IR and red). It alternates the finger-clip LEDs at 100 Hz and triggers one ADC conversion per LED phase after an optical settle time. It routes each result to the matching FIR channel as an 8-bit sample with a one-cycle valid strobe, which downstream filters use as their sample enable. Conversions that never complete are reported through a sticky error flag.

Parameters:
PHASE_CYCLES, 500000, clock cycles per LED phase (10 ms at 50 MHz); full IR+red period is 2*PHASE_CYCLES
SETTLE_CYCLES, 50000, cycles from LED turn-on to ADC_Start; must be >= 1
ADC_TIMEOUT, 1000, max cycles to wait for ADC_Done after ADC_Start; must be >= 1
Constraint: PHASE_CYCLES > SETTLE_CYCLES + ADC_TIMEOUT + 2

Ports:
CLK  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
Enable  input  1  run sequencer; low forces IDLE
ADC_Data  input  8  conversion result, valid while ADC_Done=1
ADC_Done  input  1  one-cycle conversion-complete strobe from ADC
Err_Clear  input  1  clears Timeout_Err
LED_IR  output  1  IR LED drive
LED_Red  output  1  red LED drive
ADC_Start  output  1  one-cycle conversion request
IR_ADC_Value  output  8  last IR sample, held between updates
IR_Valid  output  1  one-cycle strobe, IR_ADC_Value just updated
Red_ADC_Value  output  8  last red sample, held between updates
Red_Valid  output  1  one-cycle strobe, Red_ADC_Value just updated
Channel_Sel  output  1  0 = IR phase/IDLE, 1 = red phase
Timeout_Err  output  1  sticky: a conversion timed out

Behaviour:
- Reset: all outputs 0; state IDLE; phase counter cnt=0; wait counter wcnt=0. rst has priority over all other inputs.
- All outputs are registered. LED_IR and LED_Red are never both 1.
- States: IDLE, SETTLE, CONVERT, HOLD. A channel bit ch (driven on Channel_Sel) selects IR (0) or red (1).
- IDLE: LEDs off.
  - Enable=1 -> next cycle: SETTLE, ch=0, cnt=0, LED_IR=1.
- cnt increments every cycle outside IDLE.
- SETTLE: at the edge where cnt==SETTLE_CYCLES-1 -> CONVERT. ADC_Start=1 for exactly the next cycle; wcnt=0.
- CONVERT:
  - ADC_Done=1 sampled -> next cycle: channel register <= ADC_Data, matching Valid=1 for one cycle, state HOLD.
  - No Done when wcnt==ADC_TIMEOUT-1 -> HOLD, Timeout_Err<=1, channel register and Valid unchanged.
  - wcnt increments each CONVERT cycle.
- ADC_Done outside CONVERT is ignored, including a Done that arrives after a timeout.
- Phase end: at the edge where cnt==PHASE_CYCLES-1, in any non-IDLE state:
  - ch toggles, cnt=0, state SETTLE.
  - LED_IR and LED_Red swap in the same edge (no overlap, no gap).
  - A pending conversion is abandoned; this is unreachable under the parameter constraint.
- Latency: ADC_Done to Valid = 1 cycle. LED turn-on to ADC_Start = SETTLE_CYCLES cycles.
- Valid strobes: at most one IR_Valid per IR phase and one Red_Valid per red phase. Both are never high in the same cycle.
- Enable=0 in any state -> next cycle: IDLE, LEDs off, ADC_Start=0, cnt=wcnt=0, ch=0.
  - Sample registers and Timeout_Err are held.
  - Re-enable always restarts in the IR phase.
- Timeout_Err:
  - Cleared by Err_Clear=1 (next cycle).
  - If a timeout and Err_Clear occur in the same cycle, set wins.

Test Plan:
(Parameters for the bench: PHASE_CYCLES=20, SETTLE_CYCLES=4, ADC_TIMEOUT=8.)
1. rst=1 for 3 cycles with Enable=1 and ADC_Done toggling -> all outputs 0; after release, LED_IR=1 one cycle later; ADC_Start high exactly 4 cycles after LED_IR rises.
2. ADC model returns Done 3 cycles after each Start, data 0x5A on IR and 0xC3 on red -> IR_Valid one cycle after Done with IR_ADC_Value=0x5A; Red_Valid in the next phase with Red_ADC_Value=0xC3; LEDs swap every 20 cycles; one Start per phase.
3. ADC never asserts Done in an IR phase -> Timeout_Err=1 on the 8th cycle after Start; IR_ADC_Value keeps its prior value; no IR_Valid; red phase starts on schedule. A late Done injected afterwards is ignored. Err_Clear=1 clears the flag.
4. Drop Enable while in CONVERT, then Done arrives -> next cycle: IDLE, LEDs off; no Valid strobe. Re-enable -> IR phase restarts with cnt=0.
5. Timeout and Err_Clear in the same cycle -> Timeout_Err=1. Over 1000 cycles, assertions hold: never LED_IR & LED_Red, never IR_Valid & Red_Valid, ADC_Start width always 1.
